// File: rtl/data_mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester ids.
// Pure declarations; no logic, no latency, no backpressure.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time is chosen.
// Combinational (zero latency); backpressure is the caller's concern.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = req0 | req1;
  assign grant_id    = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer for a single-port data memory: req -> strobe +1 cycle -> done +2 cycles.
// One access per 3 cycles; requesters hold req until done. Optional range check: DATA_MEM_ARB_RANGE_CHECK_EN.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [DATA_W-1:0] mem_readData,
  output logic              busy
);

  state_t            state, state_nxt;
  logic              last_grant, grant_valid, grant_id;
  logic              lat_we, lat_id, lat_oor;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              g_we, g_oor;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              strobe_en;

  rr_arb2 u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign g_we    = grant_id ? we1    : we0;
  assign g_addr  = grant_id ? addr1  : addr0;
  assign g_wdata = grant_id ? wdata1 : wdata0;

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  assign g_oor = ({1'b0, g_addr} >= DEPTH_LIM);
`else
  logic unused_depth;
  assign unused_depth = (DEPTH != 0);
  assign g_oor        = 1'b0;
`endif

  // Reset gates the strobes so an in-flight write is never committed.
  assign strobe_en     = (state == S_ACCESS) && !lat_oor && !reset;
  assign mem_memWrite  = strobe_en && lat_we;
  assign mem_memRead   = strobe_en && !lat_we;
  assign mem_address   = lat_addr;
  assign mem_writeData = lat_wdata;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (grant_valid) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_AUX;
      lat_we     <= 1'b0;
      lat_id     <= PORT_CPU;
      lat_oor    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            lat_we     <= g_we;
            lat_id     <= grant_id;
            lat_oor    <= g_oor;
            lat_addr   <= g_addr;
            lat_wdata  <= g_wdata;
            last_grant <= grant_id;
          end
        end
        S_ACCESS: begin
          if (lat_id == PORT_CPU) begin
            done0 <= 1'b1;
            if (!lat_we && !lat_oor) rdata0 <= mem_readData;
          end else begin
            done1 <= 1'b1;
            if (!lat_we && !lat_oor) rdata1 <= mem_readData;
          end
        end
        S_DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset || state == S_DONE) begin
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else if (state == S_ACCESS) begin
      if (lat_id == PORT_CPU) err0 <= lat_oor;
      else                    err1 <= lat_oor;
    end
  end
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: table of single accesses plus hand-written
// sequences for ties, fairness, mid-access reset and early req drop.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        done0, err0, done1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic        mem_memWrite, mem_memRead, busy;

  logic [31:0] mem [256];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] shadow0, shadow1;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .rdata1(rdata1), .err1(err1),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData), .busy(busy)
  );

  // Memory model: synchronous write, combinational read, low 8 address bits.
  always @(posedge clk) if (mem_memWrite) mem[mem_address[7:0]] <= mem_writeData;
  assign mem_readData = mem[mem_address[7:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    shadow0 = '0;
    shadow1 = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.port) begin req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
    else        begin req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_memRead"}, 32'(mem_memRead), 32'(v.exp_rd));
    chk({tag, "_memWrite"}, 32'(mem_memWrite), 32'(v.exp_wr));
    chk({tag, "_addr"}, mem_address, v.addr);
    if (v.exp_wr) chk({tag, "_wdata"}, mem_writeData, v.wdata);
    @(negedge clk);
    chk({tag, "_done"}, 32'(v.port ? done1 : done0), 32'd1);
    chk({tag, "_done_other"}, 32'(v.port ? done0 : done1), 32'd0);
    chk({tag, "_err"}, 32'(v.port ? err1 : err0), 32'(v.exp_err));
    chk({tag, "_rdata"}, v.port ? rdata1 : rdata0, v.exp_rdata);
    chk({tag, "_rdata_other"}, v.port ? rdata0 : rdata1, v.port ? shadow0 : shadow1);
    if (v.port) begin req1 = 1'b0; shadow1 = v.exp_rdata; end
    else        begin req0 = 1'b0; shadow0 = v.exp_rdata; end
    @(negedge clk);
    chk({tag, "_idle_done"}, 32'(v.port ? done1 : done0), 32'd0);
    chk({tag, "_idle_err"}, 32'(v.port ? err1 : err0), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);

    //          port we  addr      wdata         rd   wr   rdata          err
    vecs[0] = '{1'b0, 1'b1, 32'd5,   32'hDEADBEEF, 1'b0, 1'b1, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'd5,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'd9,   32'hCAFE0001, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'd9,   32'h0,        1'b1, 1'b0, 32'hCAFE0001, 1'b0};
`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
    vecs[4] = '{1'b0, 1'b0, 32'd300, 32'h0,        1'b0, 1'b0, 32'hCAFE0001, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'd256, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b1};
`else
    vecs[4] = '{1'b0, 1'b0, 32'd300, 32'h0,        1'b1, 1'b0, 32'h1000_002C, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'd256, 32'h0,        1'b1, 1'b0, 32'h1000_0000, 1'b0};
`endif
    vecs[6] = '{1'b1, 1'b0, 32'd255, 32'h0,        1'b1, 1'b0, 32'h1000_00FF, 1'b0};

    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", {30'd0, done1, done0}, 32'd0);
    chk("rst_err", {30'd0, err1, err0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_strobes", {30'd0, mem_memWrite, mem_memRead}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Simultaneous requests after reset: port 0 first, twice in a row.
    for (int r = 0; r < 2; r++) begin
      if (r == 0) do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2;
      @(negedge clk);
      chk("tie_first_addr", mem_address, 32'd1);
      chk("tie_first_rd", 32'(mem_memRead), 32'd1);
      @(negedge clk);
      chk("tie_first_done", {30'd0, done1, done0}, 32'b01);
      chk("tie_first_rdata", rdata0, 32'h1000_0001);
      req0 = 1'b0;
      @(negedge clk);
      chk("tie_gap_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("tie_second_addr", mem_address, 32'd2);
      @(negedge clk);
      chk("tie_second_done", {30'd0, done1, done0}, 32'b10);
      chk("tie_second_rdata", rdata1, 32'h1000_0002);
      req1 = 1'b0;
      @(negedge clk);
    end

    // req0 held continuously, req1 raised once: grants 0,1,0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
    @(negedge clk);
    chk("fair_g0_addr", mem_address, 32'd3);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
    @(negedge clk);
    chk("fair_g0_done", {30'd0, done1, done0}, 32'b01);
    @(negedge clk);
    @(negedge clk);
    chk("fair_g1_addr", mem_address, 32'd4);
    @(negedge clk);
    chk("fair_g1_done", {30'd0, done1, done0}, 32'b10);
    chk("fair_g1_rdata", rdata1, 32'h1000_0004);
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("fair_g2_addr", mem_address, 32'd3);
    @(negedge clk);
    chk("fair_g2_done", {30'd0, done1, done0}, 32'b01);
    req0 = 1'b0;
    @(negedge clk);

    // Reset during ACCESS of a write: nothing committed, no done.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'h0000_1234;
    @(negedge clk);
    chk("rstmid_pre_wr", 32'(mem_memWrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_gated_wr", 32'(mem_memWrite), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    chk("rstmid_done", 32'(done0), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    shadow0 = '0;
    shadow1 = '0;
    @(negedge clk);
    chk("rstmid_no_late_done", 32'(done0), 32'd0);
    v = '{1'b0, 1'b0, 32'd7, 32'h0, 1'b1, 1'b0, 32'h1000_0007, 1'b0};
    run_vec(v, 7);

    // req1 dropped during ACCESS of a read: done still pulses, then idle.
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2;
    @(negedge clk);
    chk("drop_rd", 32'(mem_memRead), 32'd1);
    req1 = 1'b0;
    @(negedge clk);
    chk("drop_done", 32'(done1), 32'd1);
    chk("drop_rdata", rdata1, 32'h1000_0002);
    @(negedge clk);
    chk("drop_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("drop_stay_idle", {29'd0, busy, mem_memRead, done1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
